// File: rtl/accel_host_loader.sv
// Host-side loader/sequencer: streams words into instruction/data memory, runs the
// accelerator with a timeout, and streams data memory back out with backpressure.
module accel_host_loader #(
  parameter int unsigned NUM_SIZE    = 16,
  parameter int unsigned BUFFER_LEN  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned INSTR_DEPTH = 64,
  parameter int unsigned S_WIDTH     = 32,
  parameter int unsigned TIMEOUT     = 4096,
  localparam int unsigned LEN_W =
      $clog2((INSTR_DEPTH > BUFFER_LEN) ? INSTR_DEPTH : BUFFER_LEN) + 1,
  localparam int unsigned IA_W  = $clog2(INSTR_DEPTH),
  localparam int unsigned DA_W  = $clog2(BUFFER_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [LEN_W-1:0]       cmd_base,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [S_WIDTH-1:0]     s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [S_WIDTH-1:0]     m_data,
  output logic                   instr_we,
  output logic [IA_W-1:0]        instr_addr,
  output logic [INSTR_WIDTH-1:0] instr_wdata,
  output logic                   mem_we,
  output logic [DA_W-1:0]        mem_addr,
  output logic [NUM_SIZE-1:0]    mem_wdata,
  input  logic [NUM_SIZE-1:0]    mem_rdata,
  output logic                   acc_start,
  input  logic                   acc_done,
  output logic                   busy,
  output logic                   op_done,
  output logic                   err_len,
  output logic                   err_timeout,
  input  logic                   err_clr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [1:0] OpLoadI = 2'd0;
  localparam logic [1:0] OpLoadD = 2'd1;
  localparam logic [1:0] OpRun   = 2'd2;
  localparam logic [LEN_W:0] IDepth = (LEN_W+1)'(INSTR_DEPTH);
  localparam logic [LEN_W:0] DDepth = (LEN_W+1)'(BUFFER_LEN);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StLoadI, StLoadD, StRun, StDumpRd, StDumpOut
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       addr_q, addr_d, rem_q, rem_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic [S_WIDTH-1:0]     dump_q, dump_d;
  logic                   instr_we_q, instr_we_d;
  logic [IA_W-1:0]        instr_addr_q, instr_addr_d;
  logic [INSTR_WIDTH-1:0] instr_wdata_q, instr_wdata_d;
  logic                   mem_we_q, mem_we_d;
  logic [DA_W-1:0]        mem_addr_q, mem_addr_d;
  logic [NUM_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
  logic                   acc_start_q, acc_start_d;
  logic                   op_done_q, op_done_d;
  logic                   err_len_q, err_len_d;
  logic                   err_timeout_q, err_timeout_d;

  logic [LEN_W:0]         end_addr;
  logic                   range_err;
  logic [LEN_W-1:0]       addr_inc;
  logic [S_WIDTH-1:0]     rdata_ext;

  assign end_addr  = {1'b0, cmd_base} + {1'b0, cmd_len};
  assign range_err = (cmd_op == OpLoadI) ? (end_addr > IDepth) : (end_addr > DDepth);
  assign addr_inc  = addr_q + LEN_W'(1);
  assign rdata_ext = S_WIDTH'($signed(mem_rdata));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    first_d       = 1'b0;
    dump_d        = dump_q;
    instr_we_d    = 1'b0;
    instr_addr_d  = instr_addr_q;
    instr_wdata_d = instr_wdata_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    acc_start_d   = 1'b0;
    op_done_d     = 1'b0;
    // Clear first, so a same-cycle error event below wins.
    err_len_d     = err_len_q & ~err_clr;
    err_timeout_d = err_timeout_q & ~err_clr;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_op == OpRun) begin
            state_d     = StRun;
            acc_start_d = 1'b1;
            cnt_d       = '0;
          end else if (range_err) begin
            err_len_d = 1'b1;
          end else if (cmd_len == '0) begin
            op_done_d = 1'b1;
          end else begin
            addr_d = cmd_base;
            rem_d  = cmd_len;
            case (cmd_op)
              OpLoadI: state_d = StLoadI;
              OpLoadD: state_d = StLoadD;
              default: begin
                state_d    = StDumpRd;
                mem_addr_d = cmd_base[DA_W-1:0];
              end
            endcase
          end
        end
      end

      StLoadI, StLoadD: begin
        if (s_valid) begin
          if (state_q == StLoadI) begin
            instr_we_d    = 1'b1;
            instr_addr_d  = addr_q[IA_W-1:0];
            instr_wdata_d = s_data[INSTR_WIDTH-1:0];
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q[DA_W-1:0];
            mem_wdata_d = s_data[NUM_SIZE-1:0];
          end
          addr_d = addr_inc;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d   = StIdle;
            op_done_d = 1'b1;
          end
        end
      end

      StRun: begin
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q == 0 is the acc_start cycle; done is not trusted there.
        if (acc_done && (cnt_q != '0)) begin
          state_d   = StIdle;
          op_done_d = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d       = StIdle;
          err_timeout_d = 1'b1;
        end
      end

      StDumpRd: begin
        state_d = StDumpOut;
        first_d = 1'b1;
      end

      StDumpOut: begin
        if (first_q) begin
          dump_d = rdata_ext;
        end
        if (m_ready) begin
          addr_d = addr_inc;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d   = StIdle;
            op_done_d = 1'b1;
          end else begin
            state_d    = StDumpRd;
            mem_addr_d = addr_inc[DA_W-1:0];
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      first_q       <= 1'b0;
      dump_q        <= '0;
      instr_we_q    <= 1'b0;
      instr_addr_q  <= '0;
      instr_wdata_q <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      acc_start_q   <= 1'b0;
      op_done_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      dump_q        <= dump_d;
      instr_we_q    <= instr_we_d;
      instr_addr_q  <= instr_addr_d;
      instr_wdata_q <= instr_wdata_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      acc_start_q   <= acc_start_d;
      op_done_q     <= op_done_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign s_ready     = (state_q == StLoadI) || (state_q == StLoadD);
  assign m_valid     = (state_q == StDumpOut);
  // Read data is only guaranteed in the first output cycle; afterwards replay the capture.
  assign m_data      = first_q ? rdata_ext : dump_q;
  assign instr_we    = instr_we_q;
  assign instr_addr  = instr_addr_q;
  assign instr_wdata = instr_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign acc_start   = acc_start_q;
  assign op_done     = op_done_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;

endmodule
